spi_ram_master: RTL and testbench

SPI master that drives the 10-bit command/data frames of the SPI single-port-RAM protocol: it accepts one command at a time from a host interface and serialises it onto MOSI. For read-data commands it also deserialises the 8-bit RAM byte returned on MISO. It sits opposite the SPI slave, on the same system clock (no separate SCLK), and is the host-side endpoint for testbenches and for the top-level integration.

---
 rtl/spi_ram_pkg.sv | 34 +++
 rtl/spi_ram_master_shreg.sv | 49 ++++
 rtl/spi_ram_master.sv | 154 +++++++++++++++
 tb/tb_spi_ram_master.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_pkg
// Description : Command codes, frame sizes and FSM encoding shared by the
//               SPI single-port-RAM master and slave.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SELECT    = 3'd1;
    localparam state_t ST_SHIFT_OUT = 3'd2;
    localparam state_t ST_WAIT_RD   = 3'd3;
    localparam state_t ST_SHIFT_IN  = 3'd4;
    localparam state_t ST_DESELECT  = 3'd5;

    // Read-data frames carry a zero payload regardless of cmd_data.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [1:0]           typ,
                                                         input logic [DATA_BITS-1:0] data);
        return {typ, (typ == CMD_RD_DATA) ? {DATA_BITS{1'b0}} : data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_master_shreg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_master_shreg
// Description : 10-bit parallel-load shift register (MSB out, LSB in) with a
//               phase counter cleared on every FSM state change.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_master_shreg
    import spi_ram_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [FRAME_BITS-1:0]  load_word,
    input  logic                   shift,
    input  logic                   serial_in,
    input  logic                   cnt_clr,
    output logic                   msb,
    output logic [DATA_BITS-1:0]   low_byte,
    output logic [3:0]             cnt
);

    logic [FRAME_BITS-1:0] word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (load) begin
            word <= load_word;
        end else if (shift) begin
            word <= {word[FRAME_BITS-2:0], serial_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign msb      = word[FRAME_BITS-1];
    assign low_byte = word[DATA_BITS-1:0];

endmodule
`default_nettype wire

// File: rtl/spi_ram_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_master
// Description : Host-side SPI master issuing 10-bit command frames to the SPI
//               RAM slave and collecting the returned byte on read-data.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int RD_WAIT = 3,
    parameter int GAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_type,
    input  logic [DATA_BITS-1:0]  cmd_data,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic                  rd_valid,
    output logic                  err,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO
);

    state_t                state;
    state_t                next_state;
    logic [1:0]            cur_type;
    logic                  rd_addr_sent;
    logic                  accept;
    logic                  bad_read;
    logic [3:0]            cnt;
    logic                  msb;
    logic [DATA_BITS-1:0]  low_byte;
    logic                  shift_last;
    logic                  wait_last;
    logic                  in_last;
    logic                  gap_last;
    logic                  ss_n_d;
    logic                  mosi_d;
    logic                  sh_load;
    logic                  sh_shift;
    logic                  sh_serial_in;
    logic                  cnt_clr;

    assign cmd_ready  = (state == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign bad_read   = accept && (cmd_type == CMD_RD_DATA) && !rd_addr_sent;

    assign shift_last = (cnt == 4'(FRAME_BITS - 1));
    assign wait_last  = (cnt == 4'(RD_WAIT - 1));
    assign in_last    = (cnt == 4'(DATA_BITS - 1));
    assign gap_last   = (cnt == 4'(GAP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept && !bad_read) begin
                    next_state = ST_SELECT;
                end
            end
            ST_SELECT: begin
                next_state = ST_SHIFT_OUT;
            end
            ST_SHIFT_OUT: begin
                if (shift_last) begin
                    next_state = (cur_type == CMD_RD_DATA) ? ST_WAIT_RD : ST_DESELECT;
                end
            end
            ST_WAIT_RD: begin
                if (wait_last) begin
                    next_state = ST_SHIFT_IN;
                end
            end
            ST_SHIFT_IN: begin
                if (in_last) begin
                    next_state = ST_DESELECT;
                end
            end
            ST_DESELECT: begin
                if (gap_last) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Serial outputs are computed for the upcoming state and registered, so
    // the pins change exactly at the state boundary.
    always_comb begin
        ss_n_d       = !(next_state inside {ST_SELECT, ST_SHIFT_OUT, ST_WAIT_RD, ST_SHIFT_IN});
        mosi_d       = (next_state == ST_SHIFT_OUT) ? msb : 1'b0;
        sh_load      = accept && !bad_read;
        sh_shift     = (next_state == ST_SHIFT_OUT) || (state == ST_SHIFT_IN);
        sh_serial_in = (state == ST_SHIFT_IN) ? MISO : 1'b0;
        cnt_clr      = (next_state != state);
    end

    spi_ram_master_shreg u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_word (frame_word(cmd_type, cmd_data)),
        .shift     (sh_shift),
        .serial_in (sh_serial_in),
        .cnt_clr   (cnt_clr),
        .msb       (msb),
        .low_byte  (low_byte),
        .cnt       (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n         <= 1'b1;
            MOSI         <= 1'b0;
            cur_type     <= CMD_WR_ADDR;
            rd_addr_sent <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            err          <= 1'b0;
        end else begin
            SS_n     <= ss_n_d;
            MOSI     <= mosi_d;
            err      <= bad_read;
            rd_valid <= (state == ST_SHIFT_IN) && in_last;
            if (accept) begin
                cur_type <= cmd_type;
            end
            if ((state == ST_SHIFT_OUT) && shift_last && (cur_type == CMD_RD_ADDR)) begin
                rd_addr_sent <= 1'b1;
            end
            // The last MISO bit lands in the shift register on this same edge.
            if ((state == ST_SHIFT_IN) && in_last) begin
                rd_data <= {low_byte[DATA_BITS-2:0], MISO};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_master
// Description : Self-checking bench for spi_ram_master: per-cycle waveform
//               model, table of commands and a read-byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_master;

    localparam int RD_WAIT = 3;
    localparam int GAP     = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       err;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_rd;

    typedef struct {
        logic [1:0] t;
        logic [7:0] d;
        logic [7:0] miso;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    spi_ram_master #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_data  (cmd_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .err       (err),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one command and checks {SS_n, MOSI, rd_valid, err, cmd_ready}
    // every cycle from acceptance until cmd_ready returns.
    task automatic run_cmd(input logic [1:0] t, input logic [7:0] d, input logic [7:0] miso_byte,
                           input logic exp_err, input logic [7:0] exp_rd,
                           input bit hold, input logic [1:0] nt, input logic [7:0] nd,
                           input int abort_k, output int acc);
        logic [9:0] word;
        bit         is_rd;
        int         end_k;
        int         w;
        logic [4:0] exp_v;
        logic       e_ss;
        logic       e_mosi;
        word  = {t, (t == 2'b11) ? 8'h00 : d};
        is_rd = (t == 2'b11) && !exp_err;
        end_k = exp_err ? 1 : ((is_rd ? 20 + RD_WAIT : 12) + GAP);
        acc   = 0;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_data  = d;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (hold) begin
            cmd_type = nt;
            cmd_data = nd;
        end else begin
            cmd_valid = 1'b0;
            cmd_type  = 2'bxx;
            cmd_data  = 8'hxx;
        end
        if (is_rd && abort_k == 0) exp_q.push_back(exp_rd);
        for (int k = 1; k <= end_k; k++) begin
            @(negedge clk);
            if (is_rd && k >= 12 + RD_WAIT && k <= 19 + RD_WAIT)
                MISO = miso_byte[7 - (k - 12 - RD_WAIT)];
            else
                MISO = 1'b0;
            if (exp_err) begin
                e_ss = 1'b1;
            end else begin
                e_ss = !((k >= 1 && k <= 11) || (is_rd && k <= 19 + RD_WAIT));
            end
            e_mosi = (!exp_err && k >= 2 && k <= 11) ? word[11 - k] : 1'b0;
            exp_v  = {e_ss, e_mosi, (is_rd && k == 20 + RD_WAIT),
                      (exp_err && k == 1), (k >= end_k)};
            check($sformatf("t%0d_cyc%0d {ss,mosi,rv,err,rdy}", t, k),
                  32'({SS_n, MOSI, rd_valid, err, cmd_ready}), 32'(exp_v));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    last_rd = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(last_rd));
                end
            end
            if (abort_k != 0 && k == abort_k) begin
                #2 rst_n = 1'b0;
                #1;
                check("ss_async_on_reset", 32'({SS_n, rd_valid}), 32'b10);
                repeat (3) begin
                    @(negedge clk);
                    check("in_reset {ss,rv,err}", 32'({SS_n, rd_valid, err}), 32'b100);
                end
                MISO    = 1'b0;
                rst_n   = 1'b1;
                last_rd = 8'h00;
                return;
            end
        end
        check("rd_data_hold", 32'(rd_data), 32'(last_rd));
    endtask

    initial begin
        int t1;
        int t2;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_data  = 8'h00;
        MISO      = 1'b0;
        last_rd   = 8'h00;

        tbl[0] = '{t: 2'b11, d: 8'h00, miso: 8'h00, exp_err: 1'b1, exp_rd: 8'h00};
        tbl[1] = '{t: 2'b10, d: 8'h10, miso: 8'h00, exp_err: 1'b0, exp_rd: 8'h00};
        tbl[2] = '{t: 2'b11, d: 8'h00, miso: 8'h5A, exp_err: 1'b0, exp_rd: 8'h5A};
        tbl[3] = '{t: 2'b00, d: 8'hFF, miso: 8'h00, exp_err: 1'b0, exp_rd: 8'h00};
        tbl[4] = '{t: 2'b11, d: 8'hAB, miso: 8'hC3, exp_err: 1'b0, exp_rd: 8'hC3};
        tbl[5] = '{t: 2'b01, d: 8'h81, miso: 8'h00, exp_err: 1'b0, exp_rd: 8'h00};
        tbl[6] = '{t: 2'b11, d: 8'h00, miso: 8'h01, exp_err: 1'b0, exp_rd: 8'h01};
        tbl[7] = '{t: 2'b11, d: 8'h00, miso: 8'h80, exp_err: 1'b0, exp_rd: 8'h80};

        repeat (3) @(negedge clk);
        check("reset SS_n", 32'(SS_n), 32'd1);
        check("reset MOSI", 32'(MOSI), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", 32'(cmd_ready), 32'd1);

        // Write address then write data with cmd_valid held across both.
        run_cmd(2'b00, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b1, 2'b01, 8'hA5, 0, t1);
        run_cmd(2'b01, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 0, t2);
        check("back_to_back spacing", 32'(t2 - t1), 32'(12 + GAP));

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].t, tbl[i].d, tbl[i].miso, tbl[i].exp_err, tbl[i].exp_rd,
                    1'b0, 2'b00, 8'h00, 0, t1);
        end

        // Reset in the middle of SHIFT_IN, then read-data must error again.
        run_cmd(2'b10, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 0, t1);
        run_cmd(2'b11, 8'h00, 8'h77, 1'b0, 8'h77, 1'b0, 2'b00, 8'h00, 12 + RD_WAIT + 3, t1);
        check("rd_data cleared by reset", 32'(rd_data), 32'd0);
        run_cmd(2'b11, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 2'b00, 8'h00, 0, t1);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
